des_key_sched: RTL
==================

DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 Parameter: PARITY_CHECK, default 1, meaning 1 = check odd parity per key byte and reject bad keys, 0 = parity ignored and parity_err tied 0.
REQ-002 Clock and reset: one clock and an asynchronous active-low reset; the clock is clk (all state on its rising edge) and the reset is rst_n (asserted low, takes effect without a clock edge).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request a new schedule; sampled only in IDLE.
REQ-006 Port: key  input  [1:64]  DES key, bit 1 = MSB; sampled with accepted start.
REQ-007 Port: decrypt  input  1  0 = emit K1..K16, 1 = emit K16..K1; sampled with accepted start.
REQ-008 Port: sk_ready  input  1  consumer accepts sk this cycle.
REQ-009 Port: busy  output  1  high in every state except IDLE.
REQ-010 Port: sk_valid  output  1  sk holds a valid subkey.
REQ-011 Port: sk  output  [1:48]  subkey, bit 1 = MSB, standard DES PC-2 of current C||D.
REQ-012 Port: sk_round  output  4  emission index 0..15 of the subkey on sk.
REQ-013 Port: done  output  1  one-cycle pulse on handshake of the 16th subkey.
REQ-014 Port: parity_err  output  1  last start rejected for parity.

Function
REQ-015 States SHALL be IDLE and GEN only; the state register is 1 bit.
REQ-016 Start SHALL be accepted in a cycle with state IDLE and start=1; while not IDLE, start SHALL be ignored.
REQ-017 On acceptance with good parity (or PARITY_CHECK=0): load C||D = PC-1(key) (28+28 bits), latch decrypt, clear parity_err, go to GEN, round counter = 0.
REQ-018 On acceptance with PARITY_CHECK=1 and any key byte of even parity: set parity_err=1, stay IDLE, no sk_valid; parity_err SHALL hold until the next accepted start.
REQ-019 Shift table for key index i=1..16: 1 for i in {1,2,9,16}, else 2; rotations apply to C and D independently, 28-bit circular.
REQ-020 Encrypt: the subkey at emission n (0..15) SHALL equal PC-2 of C||D rotated left by the cumulative shift of rounds 1..n+1; the first rotation (by 1) is applied in the load cycle.
REQ-021 Decrypt: emission 0 SHALL be PC-2(PC-1(key)) (= K16, no rotation); before emission n>=1, C and D are rotated right by shift[17-n].
REQ-022 sk_valid SHALL be 1 in every GEN cycle; sk, sk_round held stable while sk_valid=1 and sk_ready=0.
REQ-023 Handshake = sk_valid and sk_ready; on handshake with sk_round<15: apply next rotation, increment sk_round, stay in GEN (back-to-back: one subkey per cycle).
REQ-024 On handshake with sk_round=15: done=1 that cycle, next state IDLE; busy stays 1 during that cycle, so a start in the same cycle is ignored.
REQ-025 Latency: first subkey valid the cycle after the accepted start; with sk_ready held 1, 16 subkeys on 16 consecutive cycles; done in the 16th.
REQ-026 In IDLE: sk_valid=0, done=0, sk_round=0; sk and C/D are don't-care-free (hold last value).
REQ-027 Key and decrypt changes during GEN SHALL have no effect on the running schedule.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, busy=0, sk_valid=0, done=0, parity_err=0, sk_round=0, C=D=0, sk=0, latched decrypt=0.
REQ-029 Reset mid-schedule SHALL abort it; no further subkeys until a new accepted start after release.

Verification
REQ-030 Encrypt: key=133457799BBCDFF1, decrypt=0, sk_ready=1 -> cycle+1 sk=1B02EFFC7072 round 0, cycle+2 sk=79AED9DBC9E5, cycle+16 sk=CB3D8B0E17F5 with done=1, then busy=0.
REQ-031 Decrypt: same key, decrypt=1 -> emission 0 = CB3D8B0E17F5, emission 14 = 79AED9DBC9E5, emission 15 = 1B02EFFC7072 with done=1.
REQ-032 Backpressure: sk_ready toggling randomly -> exactly 16 handshakes, sequence identical to REQ-030, sk stable during stalls, no duplicates or drops.
REQ-033 Parity: key=123457799BBCDFF1 (byte 12 even), PARITY_CHECK=1 -> parity_err=1, sk_valid never 1, busy stays 0; with PARITY_CHECK=0 -> full schedule, parity_err=0.
REQ-034 start pulses during GEN and in the done cycle ignored; rst_n low during emission 7 -> all outputs to reset values asynchronously, a new start then gives a full fresh 16-subkey schedule.

Source files
------------

// File: rtl/des_key_sched.sv
// des_key_sched: DES key schedule producing K1..K16 (or K16..K1 for decrypt)
// one subkey per valid/ready handshake, with optional odd-parity key rejection.
module des_key_sched #(
    parameter int PARITY_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:64] key,
    input  logic        decrypt,
    input  logic        sk_ready,
    output logic        busy,
    output logic        sk_valid,
    output logic [1:48] sk,
    output logic [3:0]  sk_round,
    output logic        done,
    output logic        parity_err
);
    typedef enum logic {IDLE, GEN} state_t;
    localparam int PC1 [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [1:48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    state_t      r_state, w_next;
    logic [1:28] r_c, r_d;
    logic [1:56] w_pc1, w_cd;
    logic [3:0]  r_round;
    logic        r_dec, r_perr;
    logic        w_bad, w_accept, w_hs, w_last, w_one;

    function automatic logic [1:28] rot(input logic [1:28] x, input logic right, input logic one);
        rot = right ? (one ? {x[28], x[1:27]} : {x[27:28], x[1:26]})
                    : (one ? {x[2:28], x[1]}  : {x[3:28], x[1:2]});
    endfunction

    always_comb begin
        w_bad = 1'b0;
        for (int b = 0; b < 8; b++) w_bad = w_bad | ~(^key[8*b+1 +: 8]);
        w_bad = w_bad & (PARITY_CHECK != 0);
        for (int i = 1; i <= 56; i++) w_pc1[i] = key[PC1[i]];
        w_cd = {r_c, r_d};
        for (int i = 1; i <= 48; i++) sk[i] = w_cd[PC2[i]];
    end

    // Encrypt uses shift[n+2], decrypt shift[16-n]; both are single shifts at n = 0, 7, 14.
    assign w_one    = (r_round == 4'd0) || (r_round == 4'd7) || (r_round == 4'd14);
    assign w_accept = (r_state == IDLE) && start;
    assign w_hs     = (r_state == GEN) && sk_ready;
    assign w_last   = (r_round == 4'd15);
    assign w_next   = (w_accept && !w_bad) ? GEN : (w_hs && w_last) ? IDLE : r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c     <= '0;
            r_d     <= '0;
            r_round <= '0;
            r_dec   <= 1'b0;
            r_perr  <= 1'b0;
        end else if (w_accept) begin
            r_perr <= w_bad;
            if (!w_bad) begin
                r_c     <= decrypt ? w_pc1[1:28]  : rot(w_pc1[1:28], 1'b0, 1'b1);
                r_d     <= decrypt ? w_pc1[29:56] : rot(w_pc1[29:56], 1'b0, 1'b1);
                r_dec   <= decrypt;
                r_round <= '0;
            end
        end else if (w_hs) begin
            r_round <= r_round + 4'd1;
            if (!w_last) begin
                r_c <= rot(r_c, r_dec, w_one);
                r_d <= rot(r_d, r_dec, w_one);
            end
        end
    end

    assign busy       = (r_state == GEN);
    assign sk_valid   = (r_state == GEN);
    assign sk_round   = r_round;
    assign done       = w_hs && w_last;
    assign parity_err = r_perr;
endmodule
